// File: rtl/gate_check_ctrl.sv
// gate_check_ctrl: clocked exhaustive-sweep controller for small combinational
// gates. Drives every N-bit input vector to two implementations, samples both
// outputs after SETTLE cycles, and records mismatches and A's truth table.
module gate_check_ctrl #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                s_a,
    input  logic                s_b,
    output logic [N-1:0]        x,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N:0]          err_count,
    output logic [N-1:0]        first_err,
    output logic                first_err_valid,
    output logic [(1<<N)-1:0]   tt_a
);

    localparam int NV = 1 << N;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    x_q, x_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pass_q, pass_d;
    logic [N:0]      err_q, err_d;
    logic [N-1:0]    ferr_q, ferr_d;
    logic            fev_q, fev_d;
    logic [NV-1:0]   tt_q, tt_d;

    // Mismatch bookkeeping helpers used on the sampling edge
    logic            mism;
    logic [N:0]      err_nx;
    logic            sample_now;
    logic            last_vec;

    assign mism       = (s_a != s_b);
    assign err_nx     = err_q + (N+1)'(mism);
    assign sample_now = (cnt_q == CW'(SETTLE - 1));
    assign last_vec   = (x_q == N'(NV - 1));

    // State and result registers; reset discards any partial sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            fev_q   <= 1'b0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            fev_q   <= fev_d;
            tt_q    <= tt_d;
        end
    end

    // Next-state logic: sweep sequencing, sampling and result update
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        fev_d   = fev_q;
        tt_d    = tt_q;

        case (state_q)
            IDLE: begin
                x_d = '0;
                if (start) begin
                    state_d = APPLY;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ferr_d  = '0;
                    fev_d   = 1'b0;
                    tt_d    = '0;
                end
            end

            APPLY: begin
                if (sample_now) begin
                    tt_d[x_q] = s_a;
                    err_d     = err_nx;
                    if (mism && !fev_q) begin
                        ferr_d = x_q;
                        fev_d  = 1'b1;
                    end
                    if (last_vec) begin
                        state_d = DONE;
                        // Verdict is registered on entry to DONE so it is
                        // already valid while done is high.
                        pass_d  = (err_nx == '0);
                    end else begin
                        x_d   = x_q + N'(1);
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                x_d     = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                x_d     = '0;
            end
        endcase
    end

    assign x               = x_q;
    assign busy            = (state_q == APPLY);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err       = ferr_q;
    assign first_err_valid = fev_q;
    assign tt_a            = tt_q;

endmodule

// File: tb/tb_gate_check_ctrl.sv
// Testbench for gate_check_ctrl: table-driven sweeps with SETTLE=1 plus
// hand-written sequences for SETTLE=3, mid-sweep reset and back-to-back runs.
module tb_gate_check_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start3;
    logic [1:0] mode1;

    logic [1:0] x1, x3;
    logic       s_a1, s_b1, s_a3, s_b3;
    logic       busy1, done1, pass1, fev1;
    logic       busy3, done3, pass3, fev3;
    logic [2:0] err1, err3;
    logic [1:0] ferr1, ferr3;
    logic [3:0] tt1, tt3;

    // Gate under test: a | ~b with a = x[1], b = x[0]
    assign s_a1 = x1[1] | ~x1[0];
    assign s_b1 = ((mode1 == 2'd1) || (mode1 == 2'd2 && x1 == 2'd2)) ? ~s_a1 : s_a1;
    assign s_a3 = x3[1] | ~x3[0];
    assign s_b3 = s_a3;

    gate_check_ctrl #(.N(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .s_a(s_a1), .s_b(s_b1),
        .x(x1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err(ferr1), .first_err_valid(fev1), .tt_a(tt1)
    );

    gate_check_ctrl #(.N(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .s_a(s_a3), .s_b(s_b3),
        .x(x3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err(ferr3), .first_err_valid(fev3), .tt_a(tt3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [2:0] err;
        logic [1:0] ferr;
        logic       fev;
        logic       pass;
        logic [3:0] tt;
    } vec_t;

    vec_t vecs[3];

    // One full SETTLE=1 sweep, starting from an IDLE cycle; ends in the
    // first IDLE cycle after done.
    task automatic sweep1(input vec_t v);
        mode1  = v.mode;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("start_busy", busy1, 1);
        chk("start_clr_err", err1, 0);
        chk("start_clr_fev", fev1, 0);
        chk("start_clr_pass", pass1, 0);
        chk("start_clr_tt", tt1, 0);
        for (int k = 0; k < 4; k++) begin
            chk("x_step", x1, k[1:0]);
            chk("busy_run", busy1, 1);
            chk("done_low_run", done1, 0);
            @(posedge clk); #1;
        end
        chk("done_pulse", done1, 1);
        chk("done_busy", busy1, 0);
        chk("done_pass", pass1, v.pass);
        chk("done_err", err1, v.err);
        chk("done_ferr", ferr1, v.ferr);
        chk("done_fev", fev1, v.fev);
        chk("done_tt", tt1, v.tt);
        @(posedge clk); #1;
        chk("idle_done_low", done1, 0);
        chk("idle_busy", busy1, 0);
        chk("idle_x", x1, 0);
        chk("hold_pass", pass1, v.pass);
        chk("hold_err", err1, v.err);
        chk("hold_ferr", ferr1, v.ferr);
        chk("hold_fev", fev1, v.fev);
        chk("hold_tt", tt1, v.tt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        mode1  = 2'd0;

        vecs[0] = '{mode: 2'd0, err: 3'd0, ferr: 2'd0, fev: 1'b0, pass: 1'b1, tt: 4'b1101};
        vecs[1] = '{mode: 2'd1, err: 3'd4, ferr: 2'd0, fev: 1'b1, pass: 1'b0, tt: 4'b1101};
        vecs[2] = '{mode: 2'd2, err: 3'd1, ferr: 2'd2, fev: 1'b1, pass: 1'b0, tt: 4'b1101};

        #22;
        chk("rst_x", x1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", err1, 0);
        chk("rst_fev", fev1, 0);
        chk("rst_tt", tt1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Consecutive entries also start in the first IDLE cycle after done
        for (int i = 0; i < 3; i++) begin
            sweep1(vecs[i]);
        end

        // SETTLE=3: each vector held three cycles; starts mid-sweep ignored
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int j = 0; j < 12; j++) begin
            chk("s3_x", x3, j / 3);
            chk("s3_busy", busy3, 1);
            chk("s3_done_low", done3, 0);
            start3 = (j == 1 || j == 6);
            @(posedge clk); #1;
        end
        start3 = 1'b0;
        chk("s3_done", done3, 1);
        chk("s3_pass", pass3, 1);
        chk("s3_err", err3, 0);
        chk("s3_fev", fev3, 0);
        chk("s3_tt", tt3, 4'b1101);
        @(posedge clk); #1;
        chk("s3_done_end", done3, 0);
        chk("s3_idle_busy", busy3, 0);

        // Reset while x=2 mid-sweep
        mode1  = 2'd0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_x", x1, 2);
        chk("mid_tt_partial", tt1, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("arst_x", x1, 0);
        chk("arst_busy", busy1, 0);
        chk("arst_done", done1, 0);
        chk("arst_pass", pass1, 0);
        chk("arst_err", err1, 0);
        chk("arst_ferr", ferr1, 0);
        chk("arst_fev", fev1, 0);
        chk("arst_tt", tt1, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", busy1, 0);
        chk("post_rst_x", x1, 0);
        sweep1(vecs[1]);
        sweep1(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
